reg_display_scanner: RTL and testbench
======================================

// Module: reg_display_scanner
// PURPOSE
//  Downstream of the multi-cycle CPU core: consumes its debug outputs (a0, v0, sp, ra, lowPC)
//  and drives a 4-digit, common-anode, time-multiplexed 7-segment display on the board.
//  The register to show is chosen by switches. The shown value is snapshotted once per scan frame.
//  This keeps the display tear-free while the CPU runs.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles per digit slot (>=2); 100 MHz -> 2 kHz digit rate
// PORTS
//  clk      in   1   system clock, same as CPU clk
//  reset    in   1   asynchronous, active-high reset
//  a0       in   16  CPU $a0 low half
//  v0       in   16  CPU $v0 low half
//  sp       in   16  CPU $sp low half
//  ra       in   16  CPU $ra low half
//  lowPC    in   8   CPU PC[7:0]
//  sel      in   3   0=a0 1=v0 2=sp 3=ra 4={8'h00,lowPC}; 5..7 invalid
//  freeze   in   1   1 = hold the current snapshot (no frame reload)
//  an       out  4   digit enables, active-low; an[k] = digit k (k=0 is least significant)
//  seg      out  7   {g,f,e,d,c,b,a}, active-low
//  dp       out  1   decimal point, active-low
// BEHAVIOUR
//  - Async reset: cnt=0, idx=0, shadow=16'h0000, err=0, an=4'b1111, seg=7'h7F, dp=1.
//    Applies immediately, including mid-frame.
//  - cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
//  - idx (2 b) advances on tick, 3->0 wrap. frame_end = tick & (idx==3).
//  - Snapshot: on frame_end with freeze=0, shadow <= mux(sel) and err <= (sel>4).
//    For invalid sel, shadow <= 16'h0000.
//  - freeze=1 at frame_end: shadow and err are held. sel changes take effect only at a frame_end.
//  - Outputs are registered, with 1-cycle latency from idx/shadow.
//    an = ~(4'b0001<<idx); seg = hex7(shadow[4*idx+:4]); dp = ~err.
//  - The first cycle after reset release drives an=4'b1110 showing digit 0 of 16'h0000 (seg=7'b1000000).
//  - The first snapshot lands at the end of the first full frame, i.e. at cycle 4*REFRESH_DIV.
//  - Exactly one an bit is low at any time after the first post-reset edge (no ghosting overlap).
//  - hex7 encodings (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//    A=08 b=03 C=46 d=21 E=06 F=0E (hex).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   - defined: a digit k>0 whose nibble and all higher nibbles of shadow are 0 shows seg=7'h7F.
//     Its an bit is still driven, so scan timing is unchanged.
//   - Digit 0 is never blanked, so 16'h0000 shows a single "0".
//   - dp still follows err.
//   - undefined: all four digits always show hex, including leading zeros.
// STRUCTURE
//  - Shared package (seg7_pkg): SEL_A0..SEL_PC selector constants, the 16-entry SEG7_HEX pattern
//    table, SEG7_BLANK=7'h7F, and the typedef for the 2-bit digit index.
//  - One sub-module: hex_to_seg7 (combinational, 4-bit nibble -> 7-bit active-low pattern).
//  - Counter, index, snapshot and output registers live in the top module.
// TESTING (REFRESH_DIV=4 in simulation)
//  1. Reset held, then released with sel=0, a0=16'h1234.
//     -> an=1110/seg=40 on the first edge.
//     -> After 16 cycles shadow=1234; the next frame shows digits 4,3,2,1 (19,30,24,79).
//     -> Each digit is held 4 cycles.
//  2. sel=4, lowPC=8'hAC.
//     -> After a frame_end the digits show C,A,0,0; dp=1 throughout.
//     -> With LEADING_ZERO_BLANK_EN, digits 2 and 3 show seg=7F.
//  3. sel=6.
//     -> After a frame_end all digits show 0 (40) with dp=0.
//     -> Return to sel=1, v0=16'hBEEF: dp=1 and digits F,E,E,b from the next frame.
//  4. freeze=1, then a0 changes 1234->FFFF over several frames.
//     -> The display stays 1234.
//     -> Drop freeze: FFFF appears after the next frame_end.
//  5. Assert reset mid-frame at idx=2.
//     -> an=1111, seg=7F, dp=1 in the same cycle, with no clock edge needed.
//     -> On release, scanning restarts at idx 0 with shadow 0000.
//  6. sel changes in the cycle of frame_end vs one cycle after.
//     -> The same-cycle value is captured.
//     -> A change one cycle late waits a full frame (4*REFRESH_DIV cycles).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: register selector codes, active-low hex patterns
// ({g,f,e,d,c,b,a}), the blank pattern and the scan digit index type.
package seg7_pkg;

  localparam logic [2:0] SEL_A0 = 3'd0;
  localparam logic [2:0] SEL_V0 = 3'd1;
  localparam logic [2:0] SEL_SP = 3'd2;
  localparam logic [2:0] SEL_RA = 3'd3;
  localparam logic [2:0] SEL_PC = 3'd4;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/reg_display_scanner_if.sv
// Debug-register bus from the CPU core plus the multiplexed 7-segment pins.
// master = CPU/board side driving registers, slave = the display scanner.
interface reg_display_scanner_if;

  logic [15:0] a0;
  logic [15:0] v0;
  logic [15:0] sp;
  logic [15:0] ra;
  logic [7:0]  lowPC;
  logic [2:0]  sel;
  logic        freeze;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output a0, v0, sp, ra, lowPC, sel, freeze,
                  input  an, seg, dp);
  modport slave  (input  a0, v0, sp, ra, lowPC, sel, freeze,
                  output an, seg, dp);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/reg_display_scanner.sv
// 4-digit common-anode scanner showing a switch-selected CPU debug register,
// snapshotted once per frame. Optional macro: LEADING_ZERO_BLANK_EN.
module reg_display_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_display_scanner_if.slave dbg
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  logic [15:0]      shadow;
  logic             err;
  logic [15:0]      sel_val;
  logic             tick;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg;
  logic [6:0]       seg_nxt;
  logic             blank;

  logic [3:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;

  assign tick      = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);

  always_comb begin
    sel_val = 16'h0000;
    case (dbg.sel)
      SEL_A0:  sel_val = dbg.a0;
      SEL_V0:  sel_val = dbg.v0;
      SEL_SP:  sel_val = dbg.sp;
      SEL_RA:  sel_val = dbg.ra;
      SEL_PC:  sel_val = {8'h00, dbg.lowPC};
      default: sel_val = 16'h0000;
    endcase
  end

  // Stage 0: slot timer, digit index and once-per-frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= 16'h0000;
      err    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
      if (frame_end && !dbg.freeze) begin
        shadow <= sel_val;
        err    <= (dbg.sel > SEL_PC);
      end
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (hex_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is never blanked so an all-zero value still shows one "0".
  assign blank = (idx != 2'd0) && ((shadow >> {idx, 2'b00}) == 16'h0000);
`else
  assign blank = 1'b0;
`endif

  assign seg_nxt = blank ? SEG7_BLANK : hex_seg;

  // Stage 1: registered pin drivers, one cycle behind idx/shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p1  <= 4'b1111;
      seg_p1 <= SEG7_BLANK;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= ~(4'b0001 << idx);
      seg_p1 <= seg_nxt;
      dp_p1  <= ~err;
    end
  end

  assign dbg.an  = an_p1;
  assign dbg.seg = seg_p1;
  assign dbg.dp  = dp_p1;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Scoreboard bench for reg_display_scanner: an edge-counting reference model queues
// the expected pins for every clock edge; a monitor compares them 1 ns after the edge.
module tb_reg_display_scanner;

  localparam int R     = 4;
  localparam int FRAME = 4 * R;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  reg_display_scanner_if dif ();

  reg_display_scanner #(.REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dif)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [15:0] ref_pick(input logic [2:0] s);
    case (s)
      3'd0:    return dif.a0;
      3'd1:    return dif.v0;
      3'd2:    return dif.sp;
      3'd3:    return dif.ra;
      3'd4:    return {8'h00, dif.lowPC};
      default: return 16'h0000;
    endcase
  endfunction

  // Reference model: edge e after release shows digit ((e-1)/R)%4 of the value
  // captured at the most recent edge that is a multiple of FRAME.
  disp_t       exp_q[$];
  int unsigned ecnt = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_err = 1'b0;

  always @(posedge clk) begin : model
    disp_t e;
    int    k;
    if (reset) begin
      ecnt     = 0;
      m_shadow = 16'h0000;
      m_err    = 1'b0;
      e        = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1};
    end else begin
      ecnt     = ecnt + 1;
      k        = int'(((ecnt - 1) / R) % 4);
      e.an     = 4'b1111;
      e.an[k]  = 1'b0;
      e.seg    = ref_hex(4'((m_shadow >> (4 * k)) & 16'h000F));
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && (m_shadow >> (4 * k)) == 16'h0000) e.seg = 7'h7F;
`endif
      e.dp     = ~m_err;
      if ((ecnt % FRAME) == 0 && !dif.freeze) begin
        m_shadow = ref_pick(dif.sel);
        m_err    = (dif.sel > 3'd4);
      end
    end
    exp_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    disp_t got;
    disp_t want;
    #1;
    vectors = vectors + 1;
    if (exp_q.size() == 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard: no expected entry at t=%0t", $time);
    end else begin
      want = exp_q.pop_front();
      got  = '{an: dif.an, seg: dif.seg, dp: dif.dp};
      if (got !== want) begin
        miscompares = miscompares + 1;
        $display("FAIL display edge=%0d: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                 ecnt, got.an, got.seg, got.dp, want.an, want.seg, want.dp);
      end
    end
  end

  task automatic wait_phase(input int unsigned ph);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (!reset && (ecnt % FRAME) == ph) return;
    end
    vectors     = vectors + 1;
    miscompares = miscompares + 1;
    $display("FAIL wait_phase: phase %0d not reached, got edge=%0d", ph, ecnt);
  endtask

  initial begin
    reset      = 1'b1;
    dif.a0     = 16'h0000;
    dif.v0     = 16'h0000;
    dif.sp     = 16'h0000;
    dif.ra     = 16'h0000;
    dif.lowPC  = 8'h00;
    dif.sel    = 3'd0;
    dif.freeze = 1'b0;
    repeat (3) @(negedge clk);

    // 1: release with a0 selected
    dif.a0 = 16'h1234;
    reset  = 1'b0;
    repeat (2 * FRAME + 4) @(negedge clk);

    // 2: lowPC with zero-extended upper digits
    dif.sel   = 3'd4;
    dif.lowPC = 8'hAC;
    repeat (2 * FRAME + 4) @(negedge clk);

    // 3: invalid selector, then v0
    dif.sel = 3'd6;
    repeat (2 * FRAME + 4) @(negedge clk);
    dif.sel = 3'd1;
    dif.v0  = 16'hBEEF;
    repeat (2 * FRAME + 4) @(negedge clk);

    // 4: freeze holds 1234 while a0 moves on
    dif.sel = 3'd0;
    dif.a0  = 16'h1234;
    repeat (2 * FRAME + 4) @(negedge clk);
    dif.freeze = 1'b1;
    dif.a0 = 16'h5678;
    repeat (FRAME) @(negedge clk);
    dif.a0 = 16'h9ABC;
    repeat (FRAME) @(negedge clk);
    dif.a0 = 16'hFFFF;
    repeat (FRAME) @(negedge clk);
    dif.freeze = 1'b0;
    repeat (2 * FRAME + 4) @(negedge clk);

    // 5: asynchronous reset in the idx=2 slot
    wait_phase(9);
    reset = 1'b1;
    #1;
    vectors = vectors + 1;
    if ({dif.an, dif.seg, dif.dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      miscompares = miscompares + 1;
      $display("FAIL async_reset: got an=%b seg=%h dp=%b, required an=1111 seg=7f dp=1",
               dif.an, dif.seg, dif.dp);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME + 4) @(negedge clk);

    // 6: selector change in the frame_end cycle vs one cycle later
    dif.sp = 16'hA5C3;
    dif.ra = 16'h0D70;
    wait_phase(FRAME - 1);
    dif.sel = 3'd2;
    repeat (FRAME + 4) @(negedge clk);
    wait_phase(0);
    dif.sel = 3'd3;
    repeat (2 * FRAME + 4) @(negedge clk);

    // Random traffic across all selectors, values and freeze
    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) dif.a0 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dif.v0 = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dif.sp = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dif.ra = 16'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) dif.lowPC = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dif.sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) dif.freeze = ~dif.freeze;
    end
    dif.freeze = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
